id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the RV32I pipelined core; sits directly downstream of the three-ported register file.
- Captures decoded fields and the two read operands rd1/rd2, and bypasses a same-cycle write-back, since the register file writes at the clock edge and does not forward internally.
- Detects load-use hazards, inserts bubbles into EX, and honours EX hold and branch flush.

---
 rtl/core_pkg.sv | 8 +
 rtl/wb_bypass.sv | 20 ++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants for the RV32I pipeline: datapath widths, the decoded-control
// bit that marks a load, and the hardwired-zero register index.
package core_pkg;
  localparam int         XLEN       = 32;
  localparam int         CTRL_W     = 16;
  localparam int         CTRL_MEMRD = 2;
  localparam logic [4:0] REG_X0     = 5'd0;
endpackage

// File: rtl/wb_bypass.sv
// Write-back bypass: returns the write-back data when it targets the source
// register in the same cycle, otherwise the stored data. x0 is never bypassed.
module wb_bypass #(
  parameter int W = core_pkg::XLEN
) (
  input  logic         wb_we_i,
  input  logic [4:0]   wb_rd_i,
  input  logic [W-1:0] wb_wd_i,
  input  logic [4:0]   rs_i,
  input  logic [W-1:0] rd_data_i,
  output logic [W-1:0] data_o
);
  import core_pkg::*;

  // Compare-and-select against the in-flight write.
  always_comb begin
    data_o = rd_data_i;
    if (wb_we_i && (wb_rd_i != REG_X0) && (wb_rd_i == rs_i)) data_o = wb_wd_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures the decoded instruction and its operands,
// covers the register file's missing internal forwarding, inserts one bubble
// per load-use hazard, and obeys EX hold and branch flush.
module id_ex_stage #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int CTRL_W = core_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2
);
  import core_pkg::*;

  localparam int NOPS = 2;

  logic                      ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]           ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
  logic [4:0]                ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0]         ex_ctrl_q, ex_ctrl_d;
  logic [NOPS-1:0][4:0]      ex_rs_q, ex_rs_d, id_rs;
  logic [NOPS-1:0][XLEN-1:0] ex_op_q, ex_op_d, rf_rd, op_n, hold_op;
  logic [NOPS-1:0]           id_use;
  logic                      load_use;

  assign id_rs  = {id_rs2, id_rs1};
  assign rf_rd  = {rf_rd2, rf_rd1};
  assign id_use = {id_use_rs2, id_use_rs1};

  // One bypass per operand on the ID side, one per operand to refresh held EX.
  for (genvar g = 0; g < NOPS; g++) begin : g_op
    wb_bypass #(.W(XLEN)) u_id_byp (
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
      .rs_i(id_rs[g]), .rd_data_i(rf_rd[g]), .data_o(op_n[g])
    );
    wb_bypass #(.W(XLEN)) u_ex_byp (
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
      .rs_i(ex_rs_q[g]), .rd_data_i(ex_op_q[g]), .data_o(hold_op[g])
    );
  end

  // Load in EX whose result the ID instruction actually reads.
  always_comb begin
    load_use = 1'b0;
    if (ex_valid_q && ex_ctrl_q[CTRL_MEMRD] && (ex_rd_q != REG_X0) && id_valid)
      load_use = (id_use[0] && (id_rs[0] == ex_rd_q)) ||
                 (id_use[1] && (id_rs[1] == ex_rd_q));
  end

  // A flushed instruction is discarded, so it never needs to stall.
  assign id_stall = ex_hold || (load_use && !flush);

  // Next-state priority: hold (with operand refresh) > flush/load-use bubble > capture.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_imm_d   = ex_imm_q;
    ex_rs_d    = ex_rs_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_op_d    = ex_op_q;
    if (ex_hold) begin
      ex_op_d = hold_op;
    end else if (flush || load_use) begin
      ex_valid_d = 1'b0;
      ex_pc_d    = '0;
      ex_imm_d   = '0;
      ex_rs_d    = '0;
      ex_rd_d    = REG_X0;
      ex_ctrl_d  = '0;
      ex_op_d    = '0;
    end else begin
      ex_valid_d = id_valid;
      ex_pc_d    = id_pc;
      ex_imm_d   = id_imm;
      ex_rs_d    = id_rs;
      ex_rd_d    = id_rd;
      ex_ctrl_d  = id_valid ? id_ctrl : '0;
      ex_op_d    = op_n;
    end
  end

  // Stage register; reset empties the slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rd_q    <= REG_X0;
      ex_ctrl_q  <= '0;
      ex_op_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs_q    <= ex_rs_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_op_q    <= ex_op_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_pc    = ex_pc_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rs1   = ex_rs_q[0];
  assign ex_rs2   = ex_rs_q[1];
  assign ex_rd    = ex_rd_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_op1   = ex_op_q[0];
  assign ex_op2   = ex_op_q[1];
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage. The model keeps an architectural register
// file: an operand in EX must always equal the newest value of its register.
module tb_id_ex_stage;
  localparam logic [15:0] LD = 16'(1) << core_pkg::CTRL_MEMRD;

  typedef struct {
    logic        id_valid;
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [15:0] ctrl;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        hold, flush;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
    logic [31:0] op1, op2;
  } ex_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [31:0] id_pc = '0, id_imm = '0, rf_rd1 = '0, rf_rd2 = '0, wb_wd = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic [15:0] id_ctrl = '0;
  logic wb_we = 1'b0, ex_hold = 1'b0, flush = 1'b0;
  logic id_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .ex_hold(ex_hold), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  ex_t exp_q[$];
  ex_t mdl = '0;
  logic [31:0] rf [32];
  ex_t act;
  assign act = '{valid: ex_valid, pc: ex_pc, imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2,
                 rd: ex_rd, ctrl: ex_ctrl, op1: ex_op1, op2: ex_op2};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, a, e, $time);
    end
  endtask

  function automatic stim_t instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic u1, input logic u2,
                                  input logic [4:0] rd, input logic [15:0] ctrl);
    stim_t s;
    s.id_valid = v; s.pc = pc; s.imm = pc ^ 32'h5A5A0000; s.rs1 = rs1; s.rs2 = rs2;
    s.u1 = u1; s.u2 = u2; s.rd = rd; s.ctrl = ctrl;
    s.we = 1'b0; s.wrd = '0; s.wd = '0; s.hold = 1'b0; s.flush = 1'b0;
    return s;
  endfunction

  // Drive one cycle at posedge+1, check the stall, then hand the expected
  // post-edge EX contents to the monitor at the edge.
  task automatic step(input stim_t s);
    logic [31:0] rfn [32];
    logic lu, stall_exp;
    ex_t nxt;
    id_valid = s.id_valid; id_pc = s.pc; id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_rd = s.rd; id_ctrl = s.ctrl;
    wb_we = s.we; wb_rd = s.wrd; wb_wd = s.wd; ex_hold = s.hold; flush = s.flush;
    rf_rd1 = rf[s.rs1]; rf_rd2 = rf[s.rs2];
    rfn = rf;
    if (s.we && s.wrd != 5'd0) rfn[s.wrd] = s.wd;
    lu = mdl.valid && mdl.ctrl[core_pkg::CTRL_MEMRD] && mdl.rd != 5'd0 && s.id_valid &&
         ((s.u1 && s.rs1 == mdl.rd) || (s.u2 && s.rs2 == mdl.rd));
    stall_exp = s.hold || (lu && !s.flush);
    #1;
    chk("id_stall", 32'(id_stall), 32'(stall_exp));
    if (s.hold) begin
      nxt = mdl;
      nxt.op1 = rfn[mdl.rs1];
      nxt.op2 = rfn[mdl.rs2];
    end else if (s.flush || lu) begin
      nxt = '0;
    end else begin
      nxt = '{valid: s.id_valid, pc: s.pc, imm: s.imm, rs1: s.rs1, rs2: s.rs2, rd: s.rd,
              ctrl: s.id_valid ? s.ctrl : 16'h0, op1: rfn[s.rs1], op2: rfn[s.rs2]};
    end
    @(posedge clk);
    exp_q.push_back(nxt);
    mdl = nxt;
    rf = rfn;
    #1;
  endtask

  // Async reset in mid-cycle: the slot must empty before any clock edge.
  task automatic mid_reset(input logic hold_during);
    ex_hold = hold_during;
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'h0);
    chk("async_rst_ctrl", 32'(ex_ctrl), 32'h0);
    mdl = '0;
    @(posedge clk);
    #1;
    chk("rst_state", 32'(act != '0), 32'h0);
    rst_n = 1'b1;
    ex_hold = 1'b0;
  endtask

  // Monitor: compare every presented EX state with the scoreboard head.
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL ex_state actual v=%b pc=%h imm=%h rs=%0d/%0d rd=%0d ctrl=%h op=%h/%h required v=%b pc=%h imm=%h rs=%0d/%0d rd=%0d ctrl=%h op=%h/%h @%0t",
                   act.valid, act.pc, act.imm, act.rs1, act.rs2, act.rd, act.ctrl, act.op1, act.op2,
                   e.valid, e.pc, e.imm, e.rs1, e.rs2, e.rd, e.ctrl, e.op1, e.op2, $time);
        end
      end
    end
  end

  initial begin
    stim_t s, prev;
    logic stalled;
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state_init", 32'(act != '0), 32'h0);
    rst_n = 1'b1;

    // First instruction after reset, then async reset with a valid slot.
    step(instr(1, 32'h100, 5'd1, 5'd2, 1, 1, 5'd3, 16'h0011));
    mid_reset(1'b0);
    step(instr(1, 32'h100, 5'd4, 5'd6, 1, 1, 5'd3, 16'h0021));

    // Write-back bypass, then x0 never bypassed.
    rf[5] = 32'h11111111;
    s = instr(1, 32'h104, 5'd5, 5'd6, 1, 1, 5'd8, 16'h0001);
    s.we = 1; s.wrd = 5'd5; s.wd = 32'hDEADBEEF;
    step(s);
    s = instr(1, 32'h108, 5'd0, 5'd0, 1, 1, 5'd8, 16'h0001);
    s.we = 1; s.wrd = 5'd0; s.wd = 32'h87654321;
    step(s);

    // Load-use: one bubble, then the consumer enters EX.
    step(instr(1, 32'h10C, 5'd1, 5'd2, 1, 0, 5'd7, LD));
    step(instr(1, 32'h110, 5'd3, 5'd7, 1, 1, 5'd9, 16'h0002));
    step(instr(1, 32'h110, 5'd3, 5'd7, 1, 1, 5'd9, 16'h0002));
    // Same register but rs2 unused: no stall.
    step(instr(1, 32'h114, 5'd1, 5'd2, 1, 0, 5'd7, LD));
    step(instr(1, 32'h118, 5'd3, 5'd7, 1, 0, 5'd9, 16'h0002));

    // Flush and load-use together: flush wins.
    step(instr(1, 32'h11C, 5'd1, 5'd2, 1, 0, 5'd7, LD));
    s = instr(1, 32'h120, 5'd3, 5'd7, 1, 1, 5'd9, 16'h0002);
    s.flush = 1;
    step(s);

    // Hold for 3 cycles with refresh of rs1 and a flush pulse that is ignored.
    step(instr(1, 32'h300, 5'd9, 5'd10, 1, 1, 5'd11, 16'h0004));
    s = instr(1, 32'h304, 5'd1, 5'd2, 1, 1, 5'd12, 16'h0004);
    s.hold = 1;
    step(s);
    s.we = 1; s.wrd = 5'd9; s.wd = 32'hCAFEF00D;
    step(s);
    s.we = 0; s.flush = 1;
    step(s);
    s.hold = 0; s.flush = 0;
    step(s);

    // Eight back-to-back non-hazard instructions.
    for (int i = 0; i < 8; i++)
      step(instr(1, 32'h200 + 32'(4 * i), 5'(i + 1), 5'(i + 9), 1, 1, 5'(i + 16), 16'h0100));

    // Reset while held.
    step(instr(1, 32'h400, 5'd1, 5'd2, 1, 1, 5'd3, LD));
    mid_reset(1'b1);

    // Randomized traffic; ID is held whenever the model says it stalled.
    stalled = 1'b0;
    prev = instr(0, '0, '0, '0, 0, 0, '0, '0);
    for (int n = 0; n < 400; n++) begin
      if (stalled) s = prev;
      else begin
        s.id_valid = ($urandom_range(0, 9) != 0);
        s.pc  = $urandom; s.imm = $urandom;
        s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) s.rs1 = 5'($urandom_range(0, 31));
        s.rd  = 5'($urandom_range(0, 7));
        s.u1  = ($urandom_range(0, 3) != 0); s.u2 = ($urandom_range(0, 2) != 0);
        s.ctrl = 16'($urandom);
        s.ctrl[core_pkg::CTRL_MEMRD] = ($urandom_range(0, 9) < 4);
      end
      s.we    = ($urandom_range(0, 9) < 6);
      s.wrd   = 5'($urandom_range(0, 9));
      s.wd    = $urandom;
      s.hold  = ($urandom_range(0, 19) < 3);
      s.flush = ($urandom_range(0, 19) < 2);
      prev = s;
      step(s);
      stalled = id_stall;
    end

    @(posedge clk);
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
